// File: rtl/super_pkg.sv
// Shared RV32 opcode constants and decode helpers.
// Reused by the issue queue hazard check and by decode.
package super_pkg;

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

    localparam logic [31:0] NOP = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] inst;
    } iq_entry_t;

    function automatic logic writes_rd(input logic [6:0] op);
        return (op != OPC_STORE) && (op != OPC_BRANCH);
    endfunction

    function automatic logic uses_rs1(input logic [6:0] op);
        return (op != OPC_LUI) && (op != OPC_AUIPC) && (op != OPC_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OPC_OP) || (op == OPC_STORE) || (op == OPC_BRANCH);
    endfunction

    function automatic logic is_mem(input logic [6:0] op);
        return (op == OPC_LOAD) || (op == OPC_STORE);
    endfunction

    function automatic logic is_ctrl(input logic [6:0] op);
        return (op == OPC_BRANCH) || (op == OPC_JAL) || (op == OPC_JALR);
    endfunction

endpackage

// File: rtl/dual_issue_queue_pair_check.sv
// Intra-pair hazard check: can the younger instruction issue
// alongside the older one in the same cycle.
import super_pkg::*;

module issue_pair_check (
    input  logic [31:0] inst_0,
    input  logic [31:0] inst_1,
    output logic        dual_ok
);

    logic [6:0] w_op0, w_op1;
    logic [4:0] w_rd0, w_rd1, w_rs1_1, w_rs2_1;
    logic       w_wr0, w_wr1;
    logic       w_raw, w_waw, w_ctrl, w_mem;
    logic       w_unused;

    assign w_op0   = inst_0[6:0];
    assign w_op1   = inst_1[6:0];
    assign w_rd0   = inst_0[11:7];
    assign w_rd1   = inst_1[11:7];
    assign w_rs1_1 = inst_1[19:15];
    assign w_rs2_1 = inst_1[24:20];

    // Source fields of the older word and funct fields play no role here.
    assign w_unused = ^{inst_0[31:12], inst_1[31:25], inst_1[14:12]};

    assign w_wr0 = writes_rd(w_op0) && (w_rd0 != 5'd0);
    assign w_wr1 = writes_rd(w_op1);

    // Classify the four hazard kinds that force single issue.
    always_comb begin
        w_raw  = w_wr0 &&
                 ((uses_rs1(w_op1) && (w_rs1_1 == w_rd0)) ||
                  (uses_rs2(w_op1) && (w_rs2_1 == w_rd0)));
        w_waw  = w_wr0 && w_wr1 && (w_rd1 == w_rd0);
        w_ctrl = is_ctrl(w_op0);
        w_mem  = is_mem(w_op0) && is_mem(w_op1);
    end

    assign dual_ok = !(w_raw || w_waw || w_ctrl || w_mem);

endmodule

// File: rtl/dual_issue_queue.sv
// In-order instruction queue between dual fetch and dual execute.
// Accepts up to two per cycle, issues 0/1/2 in order after a hazard check.
import super_pkg::*;

module dual_issue_queue #(
    parameter int DEPTH = 8
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [31:0] pc_0,
    input  logic [31:0] pc_1,
    input  logic [31:0] inst_0,
    input  logic [31:0] inst_1,
    input  logic        valid_0,
    input  logic        valid_1,
    input  logic        flush,
    input  logic        issue_stall,
    output logic        fetch_stall,
    output logic [31:0] iss_pc_0,
    output logic [31:0] iss_pc_1,
    output logic [31:0] iss_inst_0,
    output logic [31:0] iss_inst_1,
    output logic        iss_valid_0,
    output logic        iss_valid_1
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    iq_entry_t        r_mem [DEPTH];
    logic [AW-1:0]    r_head, r_tail;
    logic [CW-1:0]    r_count;

    logic             w_accept;
    logic [1:0]       w_n_acc, w_n_iss;
    logic [AW-1:0]    w_head1, w_wr1_idx;
    iq_entry_t        w_h0, w_h1;
    logic             w_dual_ok, w_iss0, w_iss1;

    // Stall is a pure function of the registered occupancy.
    assign fetch_stall = r_count > CW'(DEPTH - 2);

    assign w_accept  = !flush && !fetch_stall;
    assign w_n_acc   = w_accept ? ({1'b0, valid_0} + {1'b0, valid_1}) : 2'd0;
    assign w_wr1_idx = r_tail + AW'(valid_0);

    assign w_head1 = r_head + AW'(1);
    assign w_h0    = r_mem[r_head];
    assign w_h1    = r_mem[w_head1];

    issue_pair_check u_check (
        .inst_0  (w_h0.inst),
        .inst_1  (w_h1.inst),
        .dual_ok (w_dual_ok)
    );

    assign w_iss0  = !issue_stall && (r_count != CW'(0));
    assign w_iss1  = !issue_stall && (r_count >= CW'(2)) && w_dual_ok;
    assign w_n_iss = {1'b0, w_iss0} + {1'b0, w_iss1};

    // Entry storage: pair written in order at the tail; no reset needed.
    always_ff @(posedge clk) begin
        if (w_accept) begin
            if (valid_0) r_mem[r_tail]    <= '{pc: pc_0, inst: inst_0};
            if (valid_1) r_mem[w_wr1_idx] <= '{pc: pc_1, inst: inst_1};
        end
    end

    // Pointers and occupancy; flush empties the queue outright.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else if (flush) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
        end else begin
            r_tail  <= r_tail + AW'(w_n_acc);
            r_head  <= r_head + AW'(w_n_iss);
            r_count <= r_count + CW'(w_n_acc) - CW'(w_n_iss);
        end
    end

    // Issue registers; held while the back end stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            iss_valid_0 <= 1'b0;
            iss_valid_1 <= 1'b0;
            iss_pc_0    <= '0;
            iss_pc_1    <= '0;
            iss_inst_0  <= NOP;
            iss_inst_1  <= NOP;
        end else if (flush) begin
            iss_valid_0 <= 1'b0;
            iss_valid_1 <= 1'b0;
        end else if (!issue_stall) begin
            iss_valid_0 <= w_iss0;
            iss_valid_1 <= w_iss1;
            if (w_iss0) begin
                iss_pc_0   <= w_h0.pc;
                iss_inst_0 <= w_h0.inst;
            end
            if (w_iss1) begin
                iss_pc_1   <= w_h1.pc;
                iss_inst_1 <= w_h1.inst;
            end
        end
    end

endmodule

// File: tb/tb_dual_issue_queue.sv
// Scoreboard bench for dual_issue_queue: stimulus pushes expected
// issues in program order, a negedge monitor pops and compares.
module tb_dual_issue_queue;

    localparam logic [31:0] NOPW = 32'h0000_0013;
    localparam logic [31:0] I_A  = 32'h002081B3; // add x3,x1,x2
    localparam logic [31:0] I_B  = 32'h004202B3; // add x5,x4,x4
    localparam logic [31:0] I_C  = 32'h00308333; // reads x3
    localparam logic [31:0] I_BR = 32'h00208463;
    localparam logic [31:0] I_LD = 32'h0000A083;
    localparam logic [31:0] I_ST = 32'h0020A023;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [31:0] pc_0, pc_1, inst_0, inst_1;
    logic        valid_0, valid_1, flush, issue_stall;
    logic        fetch_stall;
    logic [31:0] iss_pc_0, iss_pc_1, iss_inst_0, iss_inst_1;
    logic        iss_valid_0, iss_valid_1;

    typedef struct {
        logic [31:0] pc;
        logic [31:0] inst;
        int          slot;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    dual_issue_queue #(.DEPTH(8)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .pc_0        (pc_0),
        .pc_1        (pc_1),
        .inst_0      (inst_0),
        .inst_1      (inst_1),
        .valid_0     (valid_0),
        .valid_1     (valid_1),
        .flush       (flush),
        .issue_stall (issue_stall),
        .fetch_stall (fetch_stall),
        .iss_pc_0    (iss_pc_0),
        .iss_pc_1    (iss_pc_1),
        .iss_inst_0  (iss_inst_0),
        .iss_inst_1  (iss_inst_1),
        .iss_valid_0 (iss_valid_0),
        .iss_valid_1 (iss_valid_1)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic pop_chk(input int slot, input logic [31:0] pc,
                           input logic [31:0] inst);
        exp_t e;
        if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL unexpected_issue slot=%0d actual_pc=%h required=none",
                     slot, pc);
        end else begin
            e = sb.pop_front();
            chk("issue_pc", pc, e.pc);
            chk("issue_inst", inst, e.inst);
            chk("issue_slot", 32'(slot), 32'(e.slot));
        end
    endtask

    // Monitor: an issue is consumed in any cycle the back end is not stalled.
    always @(negedge clk) begin
        if (rst_n && !issue_stall) begin
            chk("slot1_without_slot0",
                {31'b0, iss_valid_1 & ~iss_valid_0}, 32'd0);
            if (iss_valid_0) pop_chk(0, iss_pc_0, iss_inst_0);
            if (iss_valid_1) pop_chk(1, iss_pc_1, iss_inst_1);
        end
    end

    task automatic feed(input logic [31:0] p0, input logic [31:0] i0,
                        input logic v0, input int s0,
                        input logic [31:0] p1, input logic [31:0] i1,
                        input logic v1, input int s1);
        bit done;
        done = 0;
        pc_0 = p0; inst_0 = i0; valid_0 = v0;
        pc_1 = p1; inst_1 = i1; valid_1 = v1;
        for (int k = 0; k < 40 && !done; k++) begin
            bit acc;
            acc = !fetch_stall && !flush;
            step(1);
            if (acc) done = 1;
        end
        if (!done) begin
            checks++;
            failures++;
            $display("FAIL feed_timeout actual=stalled required=accepted pc=%h", p0);
        end else begin
            if (v0) sb.push_back('{p0, i0, s0});
            if (v1) sb.push_back('{p1, i1, s1});
        end
        valid_0 = 0;
        valid_1 = 0;
    endtask

    task automatic drain();
        issue_stall = 0;
        for (int k = 0; k < 50 && sb.size() > 0; k++) step(1);
        step(2);
        chk("drain_left", 32'(sb.size()), 32'd0);
    endtask

    initial begin
        rst_n = 0; flush = 0; issue_stall = 0;
        pc_0 = 0; pc_1 = 0; inst_0 = NOPW; inst_1 = NOPW;
        valid_0 = 0; valid_1 = 0;
        step(2);
        rst_n = 1;

        // Idle after reset.
        for (int k = 0; k < 4; k++) begin
            step(1);
            chk("rst_valid0", {31'b0, iss_valid_0}, 32'd0);
            chk("rst_valid1", {31'b0, iss_valid_1}, 32'd0);
            chk("rst_inst0", iss_inst_0, NOPW);
            chk("rst_inst1", iss_inst_1, NOPW);
            chk("rst_pc0", iss_pc_0, 32'd0);
            chk("rst_fstall", {31'b0, fetch_stall}, 32'd0);
        end

        // Independent pair: dual issue two edges after presentation.
        feed(32'h10, I_A, 1, 0, 32'h14, I_B, 1, 1);
        chk("lat_early_valid0", {31'b0, iss_valid_0}, 32'd0);
        step(1);
        chk("ind_valid0", {31'b0, iss_valid_0}, 32'd1);
        chk("ind_valid1", {31'b0, iss_valid_1}, 32'd1);
        chk("ind_pc0", iss_pc_0, 32'h10);
        chk("ind_pc1", iss_pc_1, 32'h14);
        drain();

        // RAW: younger reads x3 written by older.
        feed(32'h20, I_A, 1, 0, 32'h24, I_C, 1, 0);
        step(1);
        chk("raw1_valid0", {31'b0, iss_valid_0}, 32'd1);
        chk("raw1_valid1", {31'b0, iss_valid_1}, 32'd0);
        chk("raw1_pc0", iss_pc_0, 32'h20);
        step(1);
        chk("raw2_valid0", {31'b0, iss_valid_0}, 32'd1);
        chk("raw2_valid1", {31'b0, iss_valid_1}, 32'd0);
        chk("raw2_inst0", iss_inst_0, I_C);
        drain();

        // Control, memory and WAW pairs all single-issue.
        feed(32'h200, I_BR, 1, 0, 32'h204, I_B, 1, 0);
        step(1);
        chk("br_valid1", {31'b0, iss_valid_1}, 32'd0);
        drain();
        feed(32'h300, I_LD, 1, 0, 32'h304, I_ST, 1, 0);
        step(1);
        chk("mem_valid1", {31'b0, iss_valid_1}, 32'd0);
        drain();
        feed(32'h380, I_A, 1, 0, 32'h384, I_A, 1, 0);
        drain();
        feed(32'h3C0, I_B, 1, 0, 32'h0, NOPW, 0, 0);
        drain();

        // Back-pressure: fill to 8 with issue held.
        issue_stall = 1;
        feed(32'h100, I_A, 1, 0, 32'h104, I_B, 1, 1);
        feed(32'h108, I_A, 1, 0, 32'h10C, I_B, 1, 1);
        feed(32'h110, I_A, 1, 0, 32'h114, I_B, 1, 1);
        chk("bp_fstall_at6", {31'b0, fetch_stall}, 32'd0);
        feed(32'h118, I_A, 1, 0, 32'h11C, I_B, 1, 1);
        chk("bp_fstall_at8", {31'b0, fetch_stall}, 32'd1);
        chk("bp_held_valid0", {31'b0, iss_valid_0}, 32'd0);
        pc_0 = 32'h120; inst_0 = I_A; valid_0 = 1;
        pc_1 = 32'h124; inst_1 = I_B; valid_1 = 1;
        step(1);
        chk("bp_fstall_held", {31'b0, fetch_stall}, 32'd1);
        issue_stall = 0;
        step(1);
        chk("bp_rel_valid1", {31'b0, iss_valid_1}, 32'd1);
        chk("bp_rel_pc0", iss_pc_0, 32'h100);
        chk("bp_rel_fstall", {31'b0, fetch_stall}, 32'd0);
        feed(32'h120, I_A, 1, 0, 32'h124, I_B, 1, 1);
        drain();

        // Flush at count 5 with issue held; flush-cycle pair dropped.
        issue_stall = 1;
        feed(32'h500, I_A, 1, 0, 32'h504, I_B, 1, 1);
        feed(32'h508, I_A, 1, 0, 32'h50C, I_B, 1, 1);
        feed(32'h510, I_A, 1, 0, 32'h0, NOPW, 0, 0);
        chk("fl_count5", 32'(dut.r_count), 32'd5);
        pc_0 = 32'h600; inst_0 = I_A; valid_0 = 1;
        pc_1 = 32'h604; inst_1 = I_B; valid_1 = 1;
        flush = 1;
        step(1);
        flush = 0; valid_0 = 0; valid_1 = 0;
        sb.delete();
        chk("fl_valid0", {31'b0, iss_valid_0}, 32'd0);
        chk("fl_valid1", {31'b0, iss_valid_1}, 32'd0);
        chk("fl_fstall", {31'b0, fetch_stall}, 32'd0);
        chk("fl_count", 32'(dut.r_count), 32'd0);
        chk("fl_head", 32'(dut.r_head), 32'd0);
        chk("fl_tail", 32'(dut.r_tail), 32'd0);
        issue_stall = 0;
        step(4);
        feed(32'h700, I_A, 1, 0, 32'h704, I_B, 1, 1);
        drain();

        // Asynchronous reset while outputs are valid and queue non-empty.
        feed(32'h800, I_A, 1, 0, 32'h804, I_B, 1, 1);
        feed(32'h808, I_A, 1, 0, 32'h80C, I_B, 1, 1);
        chk("ar_pre_valid0", {31'b0, iss_valid_0}, 32'd1);
        #1 rst_n = 0;
        #1;
        chk("ar_valid0", {31'b0, iss_valid_0}, 32'd0);
        chk("ar_valid1", {31'b0, iss_valid_1}, 32'd0);
        chk("ar_inst0", iss_inst_0, NOPW);
        chk("ar_count", 32'(dut.r_count), 32'd0);
        sb.delete();
        rst_n = 1;
        step(1);
        feed(32'h900, I_B, 1, 0, 32'h904, I_A, 1, 1);
        drain();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/dual_issue_queue.md
# dual_issue_queue

Consumer end of the dual-fetch interface. Buffers the fetched instruction pair in an in-order queue, applies back-pressure to fetch, and each cycle issues 0, 1 or 2 instructions in program order to the dual execute pipes after an intra-pair hazard check. Sits between the fetch unit and the register-read/execute stages.

## Interface
- DEPTH, 8: queue entries; power of two, ≥4
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- pc_0, pc_1  in  32  PCs of the fetched pair (older, younger)
- inst_0, inst_1  in  32  instruction words of the pair
- valid_0, valid_1  in  1  pair slot valid
- flush  in  1  discard all queued and issued-but-unconsumed instructions
- issue_stall  in  1  back-end cannot accept; hold issue outputs
- fetch_stall  out  1  stall to fetch; fetch holds its pair while high
- iss_pc_0, iss_pc_1  out  32  issued PCs
- iss_inst_0, iss_inst_1  out  32  issued instruction words
- iss_valid_0, iss_valid_1  out  1  issue slot valid; slot 1 never valid without slot 0

## Operation
- Accept: when flush=0 and fetch_stall=0, write valid_0 then valid_1 entries at tail, in order. When fetch_stall=1 nothing is written; the held pair is written on the first cycle fetch_stall=0.
- fetch_stall = (count > DEPTH-2), from the registered count only; the current cycle's issue is not credited.
- Issue (issue_stall=0): head entry H0, next H1.
  - count=0: issue nothing, both iss_valid 0.
  - count≥1: H0 issues to slot 0.
  - H1 issues to slot 1 only if count≥2 and no pair hazard.
- Fields: opcode[6:0], rd[11:7], rs1[19:15], rs2[24:20].
- Writes rd: all except STORE 0100011 and BRANCH 1100011. Uses rs1: all except LUI 0110111, AUIPC 0010111, JAL 1101111. Uses rs2: OP 0110011, STORE, BRANCH.
- Pair hazard (H1 held) when any of:
  - RAW: H0 writes rd≠0 and H1 uses a source equal to it.
  - WAW: both write the same rd≠0.
  - Control: H0 is BRANCH, JAL or JALR 1100111.
  - Memory: both are LOAD 0000011 or STORE.
- issue_stall=1: outputs and head unchanged; accept still permitted.
- count_next = count + accepted − issued; full and empty are decided by count, not pointer equality. Pointers wrap modulo DEPTH.
- flush: highest priority. Next edge: count=0, head=tail=0, iss_valid_0/1=0. Inputs that cycle are not accepted, even with issue_stall=1.

## Timing
- Reset values: count=0, pointers 0, fetch_stall=0, iss_valid_0/1=0, iss_pc_0/1=0, iss_inst_0/1=0x00000013.
- Pair accepted at edge E is in queue after E and appears on iss_* after edge E+1 at the earliest. Minimum latency 2 edges from the fetch outputs being valid.
- All outputs are registered; there is no combinational path from inputs to iss_*.
- fetch_stall changes only after a clock edge; it depends only on count.
- Reset mid-operation clears all state immediately, whatever issue_stall or flush are doing.

## Structure
- Shared package super_pkg holds the opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC) and NOP 0x00000013, reused by decode.
- Sub-module issue_pair_check: combinational, takes two instruction words, outputs `dual_ok`. The queue, pointers, count and output registers live in dual_issue_queue.

## Test plan
- Reset release, no fetch valid: iss_valid_0/1=0, iss_inst_0/1=0x00000013, fetch_stall=0 indefinitely.
- Independent pair: pair 0x002081B3 / 0x004202B3 at pc 0x10/0x14 → two edges later iss_valid_0=iss_valid_1=1, iss_pc_0=0x10, iss_pc_1=0x14.
- RAW: pair 0x002081B3 (add x3) / 0x00308333 (uses x3) → slot 0 alone one cycle, then 0x00308333 in slot 0 the next cycle.
- Back-pressure: DEPTH=8, issue_stall=1, feed pairs until fetch_stall=1 at count=8 (>6). Release issue_stall → first pair issues, no entry is lost or duplicated across the stall window.
- Control/memory: BRANCH 0x00208463 followed by any instruction → single issue. LOAD 0x0000A083 + STORE 0x0020A023 → single issue.
- Flush with count=5 and issue_stall=1 → next cycle count=0, iss_valid_0/1=0, fetch_stall=0, and the pair presented during the flush cycle is not enqueued.
